mac_layer_sequencer: RTL and testbench

- Sequences one shared mac_unit through a fully-connected layer.
- For each output neuron it clears the MAC accumulator, streams cfg_len input/weight pairs from two synchronous-read buffers into the MAC, then captures the 32-bit sum and optionally applies ReLU.
- It hands each result downstream on a valid/ready port.
- It sits between the activation/weight SRAMs and the MAC, under control of the top-level inference FSM (start/done).

---
 rtl/mac_layer_sequencer_if.sv | 27 ++
 rtl/mac_layer_sequencer.sv | 130 +++++++++++++
 tb/tb_mac_layer_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_layer_sequencer_if.sv
// rtl/mac_layer_sequencer_if.sv - buffer read ports and result stream of the layer sequencer
interface mac_layer_sequencer_if #(
  parameter int LEN_W  = 8,
  parameter int NEUR_W = 8,
  parameter int W_AW   = 16
);
  logic              in_rd_en;
  logic [LEN_W-1:0]  in_addr;
  logic [7:0]        in_rdata;
  logic              w_rd_en;
  logic [W_AW-1:0]   w_addr;
  logic [7:0]        w_rdata;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [NEUR_W-1:0] res_idx;

  modport master (
    output in_rd_en, in_addr, w_rd_en, w_addr, res_valid, res_data, res_idx,
    input  in_rdata, w_rdata, res_ready
  );

  modport slave (
    input  in_rd_en, in_addr, w_rd_en, w_addr, res_valid, res_data, res_idx,
    output in_rdata, w_rdata, res_ready
  );
endinterface

// File: rtl/mac_layer_sequencer.sv
// rtl/mac_layer_sequencer.sv - drives one shared MAC through a fully-connected layer
module mac_layer_sequencer #(
  parameter int LEN_W   = 8,
  parameter int NEUR_W  = 8,
  parameter int W_AW    = 16,
  parameter int RELU_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [NEUR_W-1:0] cfg_neurons,
  output logic              busy,
  output logic              done,
  output logic              mac_clr,
  output logic [7:0]        mac_in_data,
  output logic [7:0]        mac_weight,
  output logic              mac_valid_in,
  input  logic [31:0]       mac_acc,
  mac_layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DRAIN1, S_DRAIN2, S_OUTPUT, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  k;
  logic [NEUR_W-1:0] neurons_q;
  logic [NEUR_W-1:0] neuron;
  logic [W_AW-1:0]   w_base;
  logic [31:0]       res_data_q;
  logic [NEUR_W-1:0] res_idx_q;
  logic              mac_valid_q;
  logic              last_k;
  logic              last_neuron;
  logic              cfg_empty;
  logic              fetch;

  assign last_k      = (k == len_q - LEN_W'(1));
  assign last_neuron = (neuron == neurons_q - NEUR_W'(1));
  assign cfg_empty   = (cfg_len == '0) || (cfg_neurons == '0);

  // Buffer data lands one cycle after the read, in step with mac_valid_in.
  assign mac_in_data  = bus.in_rdata;
  assign mac_weight   = bus.w_rdata;
  assign mac_valid_in = mac_valid_q;
  assign bus.res_data = res_data_q;
  assign bus.res_idx  = res_idx_q;

  always_comb begin
    state_nxt     = state;
    fetch         = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    mac_clr       = rst;
    bus.res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = cfg_empty ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        mac_clr   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        fetch = 1'b1;
        if (last_k) state_nxt = S_DRAIN1;
      end
      S_DRAIN1: state_nxt = S_DRAIN2;
      S_DRAIN2: state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = last_neuron ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    bus.in_rd_en = fetch;
    bus.w_rd_en  = fetch;
    bus.in_addr  = fetch ? k : '0;
    bus.w_addr   = fetch ? (w_base + W_AW'(k)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      neurons_q   <= '0;
      k           <= '0;
      neuron      <= '0;
      w_base      <= '0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      mac_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      mac_valid_q <= fetch;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= cfg_len;
            neurons_q <= cfg_neurons;
            neuron    <= '0;
            w_base    <= '0;
          end
        end
        S_CLEAR: k <= '0;
        S_FETCH: k <= k + LEN_W'(1);
        S_DRAIN2: begin
          res_data_q <= ((RELU_EN != 0) && mac_acc[31]) ? 32'd0 : mac_acc;
          res_idx_q  <= neuron;
        end
        S_OUTPUT: begin
          if (bus.res_ready && !last_neuron) begin
            neuron <= neuron + NEUR_W'(1);
            w_base <= w_base + W_AW'(len_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// tb/tb_mac_layer_sequencer.sv - directed bench for mac_layer_sequencer, linear and ReLU builds side by side
module tb_mac_layer_sequencer;
  localparam int LEN_W  = 8;
  localparam int NEUR_W = 8;
  localparam int W_AW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              res_ready = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [NEUR_W-1:0] cfg_neurons = '0;
  logic [7:0]        in_mem [0:255];
  logic [7:0]        w_mem  [0:255];

  logic [1:0]        busy_a, done_a, clr_a, rd_a, wrd_a, mv_a, rv_a;
  logic [LEN_W-1:0]  in_addr_a  [2];
  logic [W_AW-1:0]   w_addr_a   [2];
  logic [31:0]       res_data_a [2];
  logic [NEUR_W-1:0] res_idx_a  [2];

  // Instance 0 is the linear build, instance 1 the ReLU build; both see identical stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mac_layer_sequencer_if #(.LEN_W(LEN_W), .NEUR_W(NEUR_W), .W_AW(W_AW)) bus ();
    logic               busy, done, mac_clr, mac_valid_in;
    logic [7:0]         mac_in_data, mac_weight;
    logic signed [31:0] acc;
    logic signed [15:0] prod;

    assign bus.res_ready = res_ready;
    assign prod = $signed(mac_in_data) * $signed(mac_weight);

    always @(posedge clk) begin
      if (bus.in_rd_en) bus.in_rdata <= in_mem[bus.in_addr];
      if (bus.w_rd_en)  bus.w_rdata  <= w_mem[bus.w_addr[7:0]];
      if (mac_clr) acc <= '0;
      else if (mac_valid_in) acc <= acc + 32'(prod);
    end

    mac_layer_sequencer #(.LEN_W(LEN_W), .NEUR_W(NEUR_W), .W_AW(W_AW), .RELU_EN(g)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_len      (cfg_len),
      .cfg_neurons  (cfg_neurons),
      .busy         (busy),
      .done         (done),
      .mac_clr      (mac_clr),
      .mac_in_data  (mac_in_data),
      .mac_weight   (mac_weight),
      .mac_valid_in (mac_valid_in),
      .mac_acc      (acc),
      .bus          (bus)
    );

    assign busy_a[g]     = busy;
    assign done_a[g]     = done;
    assign clr_a[g]      = mac_clr;
    assign rd_a[g]       = bus.in_rd_en;
    assign wrd_a[g]      = bus.w_rd_en;
    assign mv_a[g]       = mac_valid_in;
    assign rv_a[g]       = bus.res_valid;
    assign in_addr_a[g]  = bus.in_addr;
    assign w_addr_a[g]   = bus.w_addr;
    assign res_data_a[g] = bus.res_data;
    assign res_idx_a[g]  = bus.res_idx;
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0, n_rd = 0, n_mv = 0, n_clr = 0, n_done = 0, n_viol = 0, n_valid = 0, n_inst = 0;
  int b_rd, b_mv, b_clr, b_done, b_viol, b_valid, b_res, b_w;
  logic        prev_rd = 1'b0;
  logic [15:0] w_log [$];
  logic [31:0] r0 [$];
  logic [31:0] r1 [$];
  logic [7:0]  ridx [$];
  int          hs_cyc [$];
  int          exp_lin [3]  = '{-2, 4, 256};
  int          exp_relu [3] = '{0, 4, 256};

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (rd_a[0]) begin n_rd++; w_log.push_back(w_addr_a[0]); end
      if (mv_a[0]) n_mv++;
      if (mv_a[0] !== prev_rd) n_viol++;
      if (clr_a[0]) n_clr++;
      if (done_a[0]) n_done++;
      if (rv_a[0]) n_valid++;
      if ({busy_a[0], done_a[0], clr_a[0], rd_a[0], wrd_a[0], mv_a[0], rv_a[0], in_addr_a[0], w_addr_a[0]} !==
          {busy_a[1], done_a[1], clr_a[1], rd_a[1], wrd_a[1], mv_a[1], rv_a[1], in_addr_a[1], w_addr_a[1]})
        n_inst++;
      if (rv_a[0] && res_ready) begin
        r0.push_back(res_data_a[0]);
        r1.push_back(res_data_a[1]);
        ridx.push_back(res_idx_a[0]);
        hs_cyc.push_back(cyc);
      end
    end
    prev_rd = rst ? 1'b0 : rd_a[0];
  end

  task automatic snap();
    b_rd = n_rd; b_mv = n_mv; b_clr = n_clr; b_done = n_done; b_viol = n_viol;
    b_valid = n_valid; b_res = r0.size(); b_w = w_log.size();
  endtask

  task automatic do_start(input int len, input int neu);
    @(negedge clk);
    cfg_len = len[7:0]; cfg_neurons = neu[7:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_len = 8'hAA; cfg_neurons = 8'h55;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy_a[0] === 1'b1 && c < 200) begin @(negedge clk); c++; end
    n_checks++;
    if (busy_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy_a[0], c);
    end
  endtask

  task automatic load_layer();
    in_mem[0] = 8'hFF; in_mem[1] = 8'h02; in_mem[2] = 8'hFD;
    w_mem[0] = 8'h01; w_mem[1] = 8'h01; w_mem[2] = 8'h01;
    w_mem[3] = 8'h02; w_mem[4] = 8'h00; w_mem[5] = 8'hFE;
    w_mem[6] = 8'h80; w_mem[7] = 8'h80; w_mem[8] = 8'h80;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_a[0], done_a[0], rd_a[0], wrd_a[0], mv_a[0], rv_a[0]} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: busy/done/rd/wrd/mv/rv=%b required 000000",
                         {busy_a[0], done_a[0], rd_a[0], wrd_a[0], mv_a[0], rv_a[0]});
    end
    n_checks++;
    if ({in_addr_a[0], w_addr_a[0], res_idx_a[0], res_data_a[0]} !== '0) begin
      n_fail++; $display("FAIL reset_data: in_addr=%0d w_addr=%0d idx=%0d data=%0d required all 0",
                         in_addr_a[0], w_addr_a[0], res_idx_a[0], res_data_a[0]);
    end
    n_checks++;
    if (clr_a !== 2'b11) begin n_fail++; $display("FAIL reset_mac_clr: got %b required 11", clr_a); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({clr_a[0], busy_a[0]} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: mac_clr/busy=%b required 00", {clr_a[0], busy_a[0]});
    end
  endtask

  task automatic test_single();
    int fv = 0, fd = 0;
    in_mem[0] = 8'd1; in_mem[1] = 8'd2; in_mem[2] = 8'd3; in_mem[3] = 8'd4;
    w_mem[0] = 8'd5; w_mem[1] = 8'd6; w_mem[2] = 8'd7; w_mem[3] = 8'd8;
    res_ready = 1'b1;
    snap();
    do_start(4, 1);
    n_checks++;
    if (clr_a[0] !== 1'b1) begin n_fail++; $display("FAIL single_clear: mac_clr=%b in cycle 1 required 1", clr_a[0]); end
    for (int c = 2; c <= 20; c++) begin
      @(negedge clk);
      if (rv_a[0] === 1'b1 && fv == 0) fv = c;
      if (done_a[0] === 1'b1 && fd == 0) fd = c;
    end
    n_checks++;
    if (fv != 8) begin n_fail++; $display("FAIL single_latency: first res_valid cycle %0d required 8", fv); end
    n_checks++;
    if (fd != 9) begin n_fail++; $display("FAIL single_done: done cycle %0d required 9", fd); end
    n_checks++;
    if (n_rd - b_rd != 4 || n_done - b_done != 1) begin
      n_fail++; $display("FAIL single_counts: reads=%0d dones=%0d required 4 and 1", n_rd - b_rd, n_done - b_done);
    end
    n_checks++;
    if (r0.size() - b_res != 1) begin
      n_fail++; $display("FAIL single_nres: got %0d results required 1", r0.size() - b_res);
    end else if (r0[b_res] !== 32'd70 || r1[b_res] !== 32'd70 || ridx[b_res] !== 8'd0) begin
      n_fail++; $display("FAIL single_result: lin=%0d relu=%0d idx=%0d required 70 70 0",
                         $signed(r0[b_res]), $signed(r1[b_res]), ridx[b_res]);
    end
  endtask

  task automatic test_layer();
    load_layer();
    res_ready = 1'b1;
    snap();
    do_start(3, 3);
    repeat (4) @(negedge clk);
    start = 1'b1; cfg_len = 8'd0; cfg_neurons = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("layer");
    n_checks++;
    if (r0.size() - b_res != 3) begin
      n_fail++; $display("FAIL layer_nres: got %0d results required 3", r0.size() - b_res);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (r0[b_res+i] !== 32'(exp_lin[i]) || r1[b_res+i] !== 32'(exp_relu[i]) || ridx[b_res+i] !== 8'(i)) begin
          n_fail++; $display("FAIL layer_res%0d: lin=%0d relu=%0d idx=%0d required %0d %0d %0d", i,
                             $signed(r0[b_res+i]), $signed(r1[b_res+i]), ridx[b_res+i], exp_lin[i], exp_relu[i], i);
        end
      end
      n_checks++;
      if (hs_cyc[b_res+1] - hs_cyc[b_res] != 7 || hs_cyc[b_res+2] - hs_cyc[b_res+1] != 7) begin
        n_fail++; $display("FAIL layer_period: periods %0d %0d required 7 7",
                           hs_cyc[b_res+1] - hs_cyc[b_res], hs_cyc[b_res+2] - hs_cyc[b_res+1]);
      end
    end
    n_checks++;
    if (w_log.size() - b_w != 9) begin
      n_fail++; $display("FAIL layer_wlen: %0d weight reads required 9", w_log.size() - b_w);
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (w_log[b_w+i] !== 16'(i)) begin
          n_fail++; $display("FAIL layer_waddr%0d: got %0d required %0d", i, w_log[b_w+i], i);
        end
      end
    end
    n_checks++;
    if (n_clr - b_clr != 3 || n_done - b_done != 1) begin
      n_fail++; $display("FAIL layer_pulses: mac_clr=%0d done=%0d required 3 and 1", n_clr - b_clr, n_done - b_done);
    end
    n_checks++;
    if (n_mv - b_mv != 9 || n_viol - b_viol != 0) begin
      n_fail++; $display("FAIL layer_mac_valid: cycles=%0d misaligned=%0d required 9 and 0", n_mv - b_mv, n_viol - b_viol);
    end
  endtask

  task automatic test_backpressure();
    int c = 0;
    int rd0;
    load_layer();
    res_ready = 1'b0;
    snap();
    do_start(3, 3);
    while (rv_a[0] !== 1'b1 && c < 30) begin @(negedge clk); c++; end
    n_checks++;
    if (rv_a[0] !== 1'b1 || c != 6) begin
      n_fail++; $display("FAIL bp_first_valid: res_valid=%b after %0d cycles required 1 after 6", rv_a[0], c);
    end
    rd0 = n_rd;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (rv_a[0] !== 1'b1 || res_data_a[0] !== 32'hFFFF_FFFE || res_data_a[1] !== 32'd0 ||
          res_idx_a[0] !== 8'd0 || rd_a[0] !== 1'b0 || clr_a[0] !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b lin=%0d relu=%0d idx=%0d rd=%b clr=%b required 1 -2 0 0 0 0", i,
                           rv_a[0], $signed(res_data_a[0]), $signed(res_data_a[1]), res_idx_a[0], rd_a[0], clr_a[0]);
      end
    end
    n_checks++;
    if (n_rd != rd0) begin n_fail++; $display("FAIL bp_no_reads: %0d reads while stalled required 0", n_rd - rd0); end
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clr_a[0], rv_a[0]} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release: mac_clr/res_valid=%b required 10", {clr_a[0], rv_a[0]});
    end
    wait_idle("bp");
    n_checks++;
    if (r0.size() - b_res != 3 || n_rd - b_rd != 9) begin
      n_fail++; $display("FAIL bp_counts: results=%0d reads=%0d required 3 and 9", r0.size() - b_res, n_rd - b_rd);
    end else if (r0[b_res] !== 32'hFFFF_FFFE || r0[b_res+1] !== 32'd4 || r0[b_res+2] !== 32'd256) begin
      n_fail++; $display("FAIL bp_results: %0d %0d %0d required -2 4 256",
                         $signed(r0[b_res]), $signed(r0[b_res+1]), $signed(r0[b_res+2]));
    end
  endtask

  task automatic test_empty();
    res_ready = 1'b1;
    snap();
    do_start(0, 2);
    n_checks++;
    if ({done_a[0], busy_a[0]} !== 2'b11) begin
      n_fail++; $display("FAIL empty_len_done: done/busy=%b required 11", {done_a[0], busy_a[0]});
    end
    start = 1'b1; cfg_len = 8'd3; cfg_neurons = 8'd3;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({done_a[0], busy_a[0]} !== 2'b00) begin
      n_fail++; $display("FAIL empty_len_idle: done/busy=%b required 00", {done_a[0], busy_a[0]});
    end
    @(negedge clk);
    n_checks++;
    if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL empty_ignored_start: busy=%b required 0", busy_a[0]); end
    do_start(3, 0);
    n_checks++;
    if (done_a[0] !== 1'b1) begin n_fail++; $display("FAIL empty_neu_done: done=%b required 1", done_a[0]); end
    @(negedge clk);
    n_checks++;
    if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL empty_neu_idle: busy=%b required 0", busy_a[0]); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_rd != b_rd || n_valid != b_valid || n_done - b_done != 2) begin
      n_fail++; $display("FAIL empty_counts: reads=%0d valids=%0d dones=%0d required 0 0 2",
                         n_rd - b_rd, n_valid - b_valid, n_done - b_done);
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    load_layer();
    res_ready = 1'b1;
    snap();
    do_start(3, 3);
    while (!(wrd_a[0] === 1'b1 && w_addr_a[0] === 16'd4) && c < 40) begin @(negedge clk); c++; end
    n_checks++;
    if (wrd_a[0] !== 1'b1 || w_addr_a[0] !== 16'd4) begin
      n_fail++; $display("FAIL mid_reach: w_rd_en=%b w_addr=%0d required 1 and 4", wrd_a[0], w_addr_a[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy_a, done_a, rd_a, wrd_a, mv_a, rv_a} !== 12'b0) begin
      n_fail++; $display("FAIL mid_ctrl: busy/done/rd/wrd/mv/rv=%b required 0",
                         {busy_a, done_a, rd_a, wrd_a, mv_a, rv_a});
    end
    n_checks++;
    if ({in_addr_a[0], w_addr_a[0], res_idx_a[0], res_data_a[0], res_data_a[1]} !== '0) begin
      n_fail++; $display("FAIL mid_data: in_addr=%0d w_addr=%0d idx=%0d data=%0d required all 0",
                         in_addr_a[0], w_addr_a[0], res_idx_a[0], $signed(res_data_a[0]));
    end
    n_checks++;
    if (clr_a !== 2'b11) begin n_fail++; $display("FAIL mid_mac_clr: got %b required 11", clr_a); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_a[0] !== 1'b0 || n_done != b_done) begin
      n_fail++; $display("FAIL mid_no_done: busy=%b dones=%0d required 0 and 0", busy_a[0], n_done - b_done);
    end
    snap();
    do_start(3, 3);
    wait_idle("mid_restart");
    n_checks++;
    if (r0.size() - b_res != 3 || n_done - b_done != 1) begin
      n_fail++; $display("FAIL mid_restart_counts: results=%0d dones=%0d required 3 and 1", r0.size() - b_res, n_done - b_done);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (r0[b_res+i] !== 32'(exp_lin[i]) || ridx[b_res+i] !== 8'(i)) begin
          n_fail++; $display("FAIL mid_restart_res%0d: data=%0d idx=%0d required %0d %0d", i,
                             $signed(r0[b_res+i]), ridx[b_res+i], exp_lin[i], i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_layer();
    test_backpressure();
    test_empty();
    test_reset_mid();
    n_checks++;
    if (n_inst != 0) begin n_fail++; $display("FAIL inst_timing: %0d cycles where builds differ, required 0", n_inst); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

endmodule
